// File: rtl/mup_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mup_responder
//  Description : MUP-side end of the pult<->MUP RS-485 link. Receives the
//                3-byte command frame (address, LED high, LED low), latches
//                the LEDs when addressed and replies with 2 button bytes and
//                3 analog bytes. Runs at 4x the line bit rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module mup_responder #(
    parameter int STOP_LEN = 8,   // idle clocks after each reply byte (4..32)
    parameter int TURN_GAP = 4,   // clocks from last stop sample to driving (2..16)
    parameter int TMO      = 63   // max clocks waiting for the next start edge
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_i,
    output logic        data_o,
    output logic        dir_485,
    input  logic [2:0]  my_addr,
    input  logic [15:0] but,
    input  logic [23:0] an_data,
    output logic [15:0] led,
    output logic        led_valid,
    output logic        busy,
    output logic        error
);

    localparam logic [2:0] c_HUNT = 3'd0;  // idle, waiting for an address byte
    localparam logic [2:0] c_RX   = 3'd1;  // receiving one byte
    localparam logic [2:0] c_GAP  = 3'd2;  // between frame bytes, timeout armed
    localparam logic [2:0] c_TURN = 3'd3;  // bus turnaround delay
    localparam logic [2:0] c_LEAD = 3'd4;  // driver on, line held high one clock
    localparam logic [2:0] c_TX   = 3'd5;  // sending the 5 reply bytes

    localparam int c_TW     = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam int c_PERIOD = 40 + STOP_LEN;

    // Input synchroniser and edge history
    logic            sync1_q, sync2_q, prev_q;
    logic            w_fall;
    logic            w_good;

    logic [2:0]      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [1:0]      idx_q, idx_d;
    logic            skip_q, skip_d;
    logic [c_TW-1:0] tmo_q, tmo_d;
    logic [7:0]      b1_q, b1_d;
    logic [15:0]     led_q, led_d;
    logic            led_valid_q, led_valid_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic            dir_q, dir_d;
    logic            data_q, data_d;
    logic [39:0]     snap_q, snap_d;
    logic [6:0]      txc_q, txc_d;
    logic [2:0]      txi_q, txi_d;
    logic [4:0]      tgap_q, tgap_d;

    // Line level for a given clock position within a reply byte
    function automatic logic f_tx_bit(input logic [6:0] pos, input logic [7:0] b);
        logic [6:0] off;
        logic       v;
        off = pos - 7'd4;
        if (pos < 7'd4)
            v = 1'b0;
        else if (pos < 7'd36)
            v = b[~off[4:2]];
        else if (pos < 7'd40)
            v = ^b;
        else
            v = 1'b1;
        return v;
    endfunction

    assign w_fall = ~sync2_q & prev_q;
    assign w_good = sync2_q & (par_q == ^shreg_q);

    // Two-flop synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Next-state logic for receiver, frame sequencing and transmitter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        idx_d       = idx_q;
        skip_d      = skip_q;
        tmo_d       = tmo_q;
        b1_d        = b1_q;
        led_d       = led_q;
        led_valid_d = 1'b0;
        busy_d      = busy_q;
        error_d     = 1'b0;
        dir_d       = dir_q;
        data_d      = data_q;
        snap_d      = snap_q;
        txc_d       = txc_q;
        txi_d       = txi_q;
        tgap_d      = tgap_q;

        case (state_q)
            c_HUNT: begin
                idx_d  = 2'd0;
                skip_d = 1'b0;
                if (w_fall) begin
                    state_d = c_RX;
                    cnt_d   = 6'd1;
                end
            end

            c_RX: begin
                cnt_d = cnt_q + 6'd1;
                // Start bit must still be low mid-bit, otherwise it was a glitch
                if (cnt_q == 6'd2 && sync2_q)
                    state_d = (idx_q == 2'd0) ? c_HUNT : c_GAP;
                if (cnt_q >= 6'd6 && cnt_q <= 6'd34 && cnt_q[1:0] == 2'b10)
                    shreg_d = {shreg_q[6:0], sync2_q};
                if (cnt_q == 6'd38)
                    par_d = sync2_q;
                if (cnt_q == 6'd42) begin
                    tmo_d = '0;
                    case (idx_q)
                        2'd0: begin
                            if (!w_good) begin
                                state_d = c_HUNT;
                            end else begin
                                // Unaddressed frames still consume their LED
                                // bytes so they are never mistaken for addresses
                                skip_d  = (shreg_q != {5'b00000, my_addr});
                                busy_d  = (shreg_q == {5'b00000, my_addr});
                                idx_d   = 2'd1;
                                state_d = c_GAP;
                            end
                        end
                        2'd1: begin
                            if (w_good) begin
                                b1_d    = shreg_q;
                                idx_d   = 2'd2;
                                state_d = c_GAP;
                            end else begin
                                error_d = ~skip_q;
                                busy_d  = 1'b0;
                                state_d = c_HUNT;
                            end
                        end
                        2'd2: begin
                            if (skip_q) begin
                                state_d = c_HUNT;
                            end else if (w_good) begin
                                led_d       = {b1_q, shreg_q};
                                led_valid_d = 1'b1;
                                snap_d      = {but, an_data};
                                tgap_d      = 5'd0;
                                state_d     = c_TURN;
                            end else begin
                                error_d = 1'b1;
                                busy_d  = 1'b0;
                                state_d = c_HUNT;
                            end
                        end
                        default: state_d = c_HUNT;
                    endcase
                end
            end

            c_GAP: begin
                if (w_fall) begin
                    state_d = c_RX;
                    cnt_d   = 6'd1;
                end else if (tmo_q == c_TW'(TMO)) begin
                    busy_d  = 1'b0;
                    skip_d  = 1'b0;
                    state_d = c_HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            c_TURN: begin
                if (tgap_q == 5'(TURN_GAP - 1)) begin
                    dir_d   = 1'b1;
                    data_d  = 1'b1;
                    state_d = c_LEAD;
                end else begin
                    tgap_d = tgap_q + 5'd1;
                end
            end

            c_LEAD: begin
                txc_d   = 7'd0;
                txi_d   = 3'd0;
                data_d  = 1'b0;
                state_d = c_TX;
            end

            c_TX: begin
                if (txc_q == 7'(c_PERIOD - 1)) begin
                    if (txi_q == 3'd4) begin
                        dir_d   = 1'b0;
                        busy_d  = 1'b0;
                        data_d  = 1'b1;
                        state_d = c_HUNT;
                    end else begin
                        txi_d  = txi_q + 3'd1;
                        txc_d  = 7'd0;
                        snap_d = {snap_q[31:0], 8'h00};
                        data_d = 1'b0;
                    end
                end else begin
                    txc_d  = txc_q + 7'd1;
                    data_d = f_tx_bit(txc_q + 7'd1, snap_q[39:32]);
                end
            end

            default: state_d = c_HUNT;
        endcase
    end

    // State and output registers; reset aborts any activity and frees the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_HUNT;
            cnt_q       <= 6'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            idx_q       <= 2'd0;
            skip_q      <= 1'b0;
            tmo_q       <= '0;
            b1_q        <= 8'h00;
            led_q       <= 16'h0000;
            led_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            dir_q       <= 1'b0;
            data_q      <= 1'b1;
            snap_q      <= 40'h0;
            txc_q       <= 7'd0;
            txi_q       <= 3'd0;
            tgap_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            b1_q        <= b1_d;
            led_q       <= led_d;
            led_valid_q <= led_valid_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            snap_q      <= snap_d;
            txc_q       <= txc_d;
            txi_q       <= txi_d;
            tgap_q      <= tgap_d;
        end
    end

    assign data_o    = data_q;
    assign dir_485   = dir_q;
    assign led       = led_q;
    assign led_valid = led_valid_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mup_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mup_responder
//  Description : Directed self-checking bench for mup_responder: normal
//                frame/reply, unaddressed frame, parity error, timeout,
//                line glitch and reset during a reply.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mup_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_i;
    logic        data_o;
    logic        dir_485;
    logic [2:0]  my_addr;
    logic [15:0] but;
    logic [23:0] an_data;
    logic [15:0] led;
    logic        led_valid;
    logic        busy;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters, only written by the monitor below
    int lv_cnt   = 0;
    int err_cnt  = 0;
    int dir_cnt  = 0;
    int busy_cnt = 0;

    mup_responder #(.STOP_LEN(8), .TURN_GAP(4), .TMO(63)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .data_o   (data_o),
        .dir_485  (dir_485),
        .my_addr  (my_addr),
        .but      (but),
        .an_data  (an_data),
        .led      (led),
        .led_valid(led_valid),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Count output activity, sampled away from the active edge
    always @(negedge clk) begin
        if (led_valid) lv_cnt   <= lv_cnt + 1;
        if (error)     err_cnt  <= err_cnt + 1;
        if (dir_485)   dir_cnt  <= dir_cnt + 1;
        if (busy)      busy_cnt <= busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One line bit = 4 clocks, driven from a negedge
    task automatic send_bit(input logic v);
        data_i = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit((^b) ^ flip);
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic flip_l);
        send_byte(a, 1'b0);
        send_byte(h, 1'b0);
        send_byte(l, flip_l);
    endtask

    // Wait (bounded) for a start bit from the DUT and decode one reply byte
    task automatic recv_byte(output logic [7:0] b, output logic p, output logic frm_ok,
                             output int w, output logic got);
        b = 8'h00; p = 1'b0; frm_ok = 1'b0; got = 1'b0; w = 0;
        while (w < 200 && !(data_o == 1'b0 && dir_485 == 1'b1)) begin
            @(negedge clk);
            w++;
        end
        if (w < 200) begin
            got = 1'b1;
            repeat (2) @(negedge clk);
            frm_ok = ~data_o;
            for (int j = 0; j < 8; j++) begin
                repeat (4) @(negedge clk);
                b = {b[6:0], data_o};
            end
            repeat (4) @(negedge clk);
            p = data_o;
            repeat (4) @(negedge clk);
            frm_ok = frm_ok & data_o;
        end
    endtask

    // Check a full 5-byte reply; exp_par[4] belongs to the first byte
    task automatic check_reply(input logic [39:0] exp_b, input logic [4:0] exp_par);
        logic [7:0] b;
        logic       p, fo, got;
        int         w;
        logic [39:0] eb;
        eb = exp_b;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b, p, fo, w, got);
            check_eq($sformatf("reply%0d_seen", i), 32'(got), 32'd1);
            check_eq($sformatf("reply%0d_byte", i), 32'(b), 32'(eb[39:32]));
            check_eq($sformatf("reply%0d_par", i), 32'(p), 32'(exp_par[4 - i]));
            check_eq($sformatf("reply%0d_frame", i), 32'(fo), 32'd1);
            if (i == 0) check_eq("first_start_latency_lt64", 32'(w < 64), 32'd1);
            eb = {eb[31:0], 8'h00};
        end
        repeat (8) @(negedge clk);
        check_eq("dir_released", 32'(dir_485), 32'd0);
        check_eq("busy_after_reply", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lv_b, err_b, dir_b, busy_b, w;

        rst     = 1'b1;
        data_i  = 1'b1;
        my_addr = 3'd5;
        but     = 16'h1234;
        an_data = 24'hABCDEF;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_data_o", 32'(data_o), 32'd1);
        check_eq("rst_dir", 32'(dir_485), 32'd0);
        check_eq("rst_led", 32'(led), 32'd0);
        check_eq("rst_led_valid", 32'(led_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: addressed frame, reply from snapshot taken at the last LED byte
        lv_b = lv_cnt; dir_b = dir_cnt;
        send_frame(8'h05, 8'hA5, 8'h3C, 1'b0);
        @(negedge clk);
        but = 16'hDEAD; an_data = 24'h000000;
        check_reply(40'h1234ABCDEF, 5'b01111);
        check_eq("t1_led", 32'(led), 32'hA53C);
        check_eq("t1_led_valid_pulses", lv_cnt - lv_b, 32'd1);
        check_eq("t1_dir_high_clks", dir_cnt - dir_b, 32'd241);
        but = 16'h1234; an_data = 24'hABCDEF;

        // 2: frame for another address whose LED bytes equal my address
        lv_b = lv_cnt; dir_b = dir_cnt; busy_b = busy_cnt; err_b = err_cnt;
        send_frame(8'h03, 8'h05, 8'h05, 1'b0);
        repeat (120) @(negedge clk);
        check_eq("t2_no_dir", dir_cnt - dir_b, 32'd0);
        check_eq("t2_no_busy", busy_cnt - busy_b, 32'd0);
        check_eq("t2_led", 32'(led), 32'hA53C);
        check_eq("t2_no_led_valid", lv_cnt - lv_b, 32'd0);
        check_eq("t2_no_error", err_cnt - err_b, 32'd0);

        // 3: addressed frame with bad parity on the LED low byte
        lv_b = lv_cnt; dir_b = dir_cnt; err_b = err_cnt;
        send_frame(8'h05, 8'h11, 8'h22, 1'b1);
        repeat (100) @(negedge clk);
        check_eq("t3_error_pulses", err_cnt - err_b, 32'd1);
        check_eq("t3_led", 32'(led), 32'hA53C);
        check_eq("t3_no_led_valid", lv_cnt - lv_b, 32'd0);
        check_eq("t3_no_dir", dir_cnt - dir_b, 32'd0);
        check_eq("t3_busy", 32'(busy), 32'd0);

        // 4: addressed frame abandoned after the LED high byte
        dir_b = dir_cnt; err_b = err_cnt;
        send_byte(8'h05, 1'b0);
        send_byte(8'h77, 1'b0);
        repeat (62) @(negedge clk);
        check_eq("t4_busy_before_tmo", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("t4_busy_after_tmo", 32'(busy), 32'd0);
        check_eq("t4_no_error", err_cnt - err_b, 32'd0);
        check_eq("t4_no_dir", dir_cnt - dir_b, 32'd0);

        // 5: one-clock glitch on the idle line, then a valid frame
        busy_b = busy_cnt;
        data_i = 1'b0;
        @(negedge clk);
        data_i = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("t5_glitch_no_busy", busy_cnt - busy_b, 32'd0);
        but = 16'h8001; an_data = 24'h00FF00;
        send_frame(8'h05, 8'h5A, 8'hC3, 1'b0);
        check_reply(40'h800100FF00, 5'b11000);
        check_eq("t5_led", 32'(led), 32'h5AC3);

        // 6: reset while the third reply byte is on the line
        but = 16'h1234; an_data = 24'hABCDEF;
        send_frame(8'h05, 8'h0F, 8'hF0, 1'b0);
        begin
            logic [7:0] b;
            logic       p, fo, got;
            recv_byte(b, p, fo, w, got);
            recv_byte(b, p, fo, w, got);
            check_eq("t6_second_byte", 32'(b), 32'h34);
        end
        w = 0;
        while (w < 200 && data_o != 1'b0) begin
            @(negedge clk);
            w++;
        end
        check_eq("t6_third_start_seen", 32'(w < 200), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_dir", 32'(dir_485), 32'd0);
        check_eq("t6_rst_data_o", 32'(data_o), 32'd1);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_led", 32'(led), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h05, 8'h66, 8'h99, 1'b0);
        check_reply(40'h1234ABCDEF, 5'b01111);
        check_eq("t6_led", 32'(led), 32'h6699);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
